driver_sin_decoder: RTL and testbench

DRIVER_SIN_DECODER -- requirements
Module: driver_sin_decoder

---
 rtl/driver_sin_decoder.sv | 145 ++++++++++++++
 tb/tb_driver_sin_decoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/driver_sin_decoder.sv
// Decodes the driver controller's serial command stream: models the driver's
// common shift register, counts sclk edges inside each LAT window and acts on the result.
module driver_sin_decoder #(
  parameter int SR_WIDTH    = 48,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_hse,
  input  logic                rst,
  input  logic                driver_sclk,
  input  logic                driver_lat,
  input  logic                driver_sin,
  output logic                driver_sout,
  output logic                cmd_valid,
  output logic [2:0]          cmd_code,
  output logic [SR_WIDTH-1:0] cmd_data,
  output logic [4:0]          gs_count,
  output logic [SR_WIDTH-1:0] cfg_data,
  output logic                cmd_err
);

  typedef enum logic [2:0] {
    C_INV       = 3'd0,
    C_WRTGS     = 3'd1,
    C_LATGS     = 3'd2,
    C_WRTCFG    = 3'd3,
    C_LINERESET = 3'd4,
    C_READFC    = 3'd5,
    C_TMGRST    = 3'd6,
    C_FCWRTEN   = 3'd7
  } cmd_e;

  // All three lines share one chain so sin stays aligned with sclk.
  // Bit order in each stage: {sin, lat, sclk}.
  logic [SYNC_STAGES-1:0][2:0] r_sync;
  logic                        r_sclk_d;
  logic                        r_lat_d;
  logic [SR_WIDTH-1:0]         r_sr;
  logic [4:0]                  r_cnt;
  logic                        r_we;
  logic [4:0]                  r_gs;
  logic [SR_WIDTH-1:0]         r_cfg;
  logic [2:0]                  r_code;
  logic [SR_WIDTH-1:0]         r_data;
  logic                        r_valid;
  logic                        r_err;
  logic                        r_sout;

  logic [2:0]          w_sync;
  logic                w_sclk;
  logic                w_lat;
  logic                w_sin;
  logic                w_sclk_rise;
  logic                w_lat_rise;
  logic                w_lat_fall;
  logic [SR_WIDTH-1:0] w_sr_shift;
  logic [4:0]          w_cnt_base;
  logic [4:0]          w_cnt_next;
  cmd_e                w_code;
  logic                w_err;

  assign w_sync      = r_sync[SYNC_STAGES-1];
  assign w_sclk      = w_sync[0];
  assign w_lat       = w_sync[1];
  assign w_sin       = w_sync[2];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_lat_rise  = w_lat & ~r_lat_d;
  assign w_lat_fall  = ~w_lat & r_lat_d;

  assign w_sr_shift = w_sclk_rise ? {r_sr[SR_WIDTH-2:0], w_sin} : r_sr;

  // r_lat_d keeps an sclk rise coincident with the lat fall inside the window.
  assign w_cnt_base = w_lat_rise ? 5'd0 : r_cnt;
  assign w_cnt_next = (w_sclk_rise && (w_lat || r_lat_d) && (w_cnt_base != 5'd31))
                      ? w_cnt_base + 5'd1 : w_cnt_base;

  always_comb begin
    w_code = C_INV;
    case (w_cnt_next)
      5'd1:    w_code = C_WRTGS;
      5'd3:    w_code = C_LATGS;
      5'd5:    w_code = C_WRTCFG;
      5'd7:    w_code = C_LINERESET;
      5'd11:   w_code = C_READFC;
      5'd13:   w_code = C_TMGRST;
      5'd15:   w_code = C_FCWRTEN;
      default: w_code = C_INV;
    endcase
  end

  assign w_err = (w_code == C_INV) || ((w_code == C_WRTCFG) && !r_we);

  always_ff @(posedge clk_hse) begin
    if (rst) begin
      r_sync   <= '0;
      r_sclk_d <= 1'b0;
      r_lat_d  <= 1'b0;
      r_sr     <= '0;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_gs     <= '0;
      r_cfg    <= '0;
      r_code   <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_sout   <= 1'b0;
    end else begin
      r_sync[0] <= {driver_sin, driver_lat, driver_sclk};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_sclk_d <= w_sclk;
      r_lat_d  <= w_lat;
      r_sr     <= w_sr_shift;
      r_cnt    <= w_cnt_next;
      r_sout   <= r_sr[SR_WIDTH-1];
      r_valid  <= w_lat_fall;
      r_err    <= w_lat_fall & w_err;
      if (w_lat_fall) begin
        r_code <= w_code;
        r_data <= w_sr_shift;
        case (w_code)
          C_WRTGS:              if (r_gs != 5'd31) r_gs <= r_gs + 5'd1;
          C_LATGS, C_LINERESET: r_gs <= '0;
          C_WRTCFG:
            if (r_we) begin
              r_cfg <= w_sr_shift;
              r_we  <= 1'b0;
            end
          // Load wins over any shift in this cycle.
          C_READFC:             r_sr <= r_cfg;
          C_FCWRTEN:            r_we <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign driver_sout = r_sout;
  assign cmd_valid   = r_valid;
  assign cmd_code    = r_code;
  assign cmd_data    = r_data;
  assign gs_count    = r_gs;
  assign cfg_data    = r_cfg;
  assign cmd_err     = r_err;

endmodule

// File: tb/tb_driver_sin_decoder.sv
// Bench for driver_sin_decoder: directed sclk/lat/sin sequences, a command-level
// model that predicts each decode, and a per-cycle compare against it.
module tb_driver_sin_decoder;
  localparam int SRW = 48;
  localparam int SS  = 2;

  logic           clk_hse = 1'b0;
  logic           rst = 1'b1;
  logic           driver_sclk = 1'b0;
  logic           driver_lat = 1'b0;
  logic           driver_sin = 1'b0;
  logic           driver_sout, cmd_valid, cmd_err;
  logic [2:0]     cmd_code;
  logic [SRW-1:0] cmd_data, cfg_data;
  logic [4:0]     gs_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  driver_sin_decoder #(.SR_WIDTH(SRW), .SYNC_STAGES(SS)) dut (
    .clk_hse(clk_hse), .rst(rst), .driver_sclk(driver_sclk), .driver_lat(driver_lat),
    .driver_sin(driver_sin), .driver_sout(driver_sout), .cmd_valid(cmd_valid),
    .cmd_code(cmd_code), .cmd_data(cmd_data), .gs_count(gs_count),
    .cfg_data(cfg_data), .cmd_err(cmd_err)
  );

  always #5 clk_hse = ~clk_hse;
  always @(posedge clk_hse) cyc <= cyc + 1;

  typedef struct {
    int             due;
    logic [2:0]     code;
    logic [SRW-1:0] data;
    logic           err;
    logic [4:0]     gs;
    logic [SRW-1:0] cfg;
  } exp_t;

  exp_t q[$];
  exp_t ce;

  // Command-level model of the driver
  logic [SRW-1:0] m_sr = '0, m_cfg = '0;
  int             m_cnt = 0, m_gs = 0;
  logic           m_lat = 1'b0, m_we = 1'b0;

  // Last decode the DUT should be holding
  logic [2:0]     cur_code = '0;
  logic [SRW-1:0] cur_data = '0, cur_cfg = '0;
  logic [4:0]     cur_gs = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int decode(input int n);
    int tbl[7] = '{1, 3, 5, 7, 11, 13, 15};
    for (int i = 0; i < 7; i++) if (n == tbl[i]) return i + 1;
    return 0;
  endfunction

  task automatic nclk(input int n);
    repeat (n) @(negedge clk_hse);
  endtask

  task automatic pulse(input logic b);
    driver_sin = b;
    nclk(3);
    chk("sout", 64'(driver_sout), 64'(m_sr[SRW-1]));
    driver_sclk = 1'b1;
    m_sr = {m_sr[SRW-2:0], b};
    if (m_lat && m_cnt < 31) m_cnt++;
    nclk(3);
    driver_sclk = 1'b0;
  endtask

  task automatic lat_rise();
    driver_lat = 1'b1;
    m_lat = 1'b1;
    m_cnt = 0;
    nclk(3);
  endtask

  task automatic lat_fall();
    exp_t e;
    int   code;
    driver_lat = 1'b0;
    m_lat = 1'b0;
    code = decode(m_cnt);
    e.due  = cyc + SS + 1;
    e.code = 3'(code);
    e.data = m_sr;
    e.err  = (code == 0) || (code == 3 && !m_we);
    case (code)
      1: if (m_gs < 31) m_gs++;
      2, 4: m_gs = 0;
      3: if (m_we) begin m_cfg = m_sr; m_we = 1'b0; end
      5: m_sr = m_cfg;
      7: m_we = 1'b1;
      default: ;
    endcase
    e.gs  = 5'(m_gs);
    e.cfg = m_cfg;
    q.push_back(e);
    nclk(6);
  endtask

  task automatic cmd(input int n);
    lat_rise();
    repeat (n) pulse(1'b0);
    lat_fall();
  endtask

  task automatic send_word(input logic [SRW-1:0] w, input int n);
    for (int i = SRW - 1; i >= 0; i--) begin
      if (i == n - 1) lat_rise();
      pulse(w[i]);
    end
    lat_fall();
  endtask

  task automatic do_reset(input logic keep_lat);
    rst = 1'b1;
    driver_sclk = 1'b0;
    driver_sin = 1'b0;
    q.delete();
    cur_code = '0; cur_data = '0; cur_cfg = '0; cur_gs = '0;
    m_sr = '0; m_cfg = '0; m_cnt = 0; m_gs = 0; m_we = 1'b0;
    nclk(3);
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_err",   64'(cmd_err),   64'd0);
    chk("rst_code",  64'(cmd_code),  64'd0);
    chk("rst_data",  64'(cmd_data),  64'd0);
    chk("rst_gs",    64'(gs_count),  64'd0);
    chk("rst_cfg",   64'(cfg_data),  64'd0);
    chk("rst_sout",  64'(driver_sout), 64'd0);
    rst = 1'b0;
    m_lat = keep_lat & driver_lat;
    driver_lat = m_lat;
    nclk(4);
  endtask

  // Every cycle: a pulse exactly when a decode is due, held values otherwise.
  always @(negedge clk_hse) begin
    if (!rst) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        ce = q.pop_front();
        chk("valid_pulse", 64'(cmd_valid), 64'd1);
        chk("code",  64'(cmd_code), 64'(ce.code));
        chk("data",  64'(cmd_data), 64'(ce.data));
        chk("err",   64'(cmd_err),  64'(ce.err));
        chk("gs",    64'(gs_count), 64'(ce.gs));
        chk("cfg",   64'(cfg_data), 64'(ce.cfg));
        cur_code = ce.code; cur_data = ce.data; cur_gs = ce.gs; cur_cfg = ce.cfg;
      end else begin
        if (q.size() > 0 && q[0].due < cyc) begin
          chk("decode_missed", 64'(q[0].due), 64'(cyc));
          void'(q.pop_front());
        end
        chk("valid_idle", 64'(cmd_valid), 64'd0);
        chk("err_idle",   64'(cmd_err),   64'd0);
        chk("code_hold",  64'(cmd_code),  64'(cur_code));
        chk("data_hold",  64'(cmd_data),  64'(cur_data));
        chk("gs_hold",    64'(gs_count),  64'(cur_gs));
        chk("cfg_hold",   64'(cfg_data),  64'(cur_cfg));
      end
    end
  end

  initial begin
    logic [SRW-1:0] v;
    v = '0;
    do_reset(1'b0);

    // Single WRTGS carrying a full word
    send_word(48'hA5A5_0000_FFFF, 1);
    chk("wrtgs_code", 64'(cmd_code), 64'd1);
    chk("wrtgs_data", 64'(cmd_data), 64'hA5A5_0000_FFFF);
    chk("wrtgs_gs",   64'(gs_count), 64'd1);

    // 16 WRTGS then LATGS
    do_reset(1'b0);
    repeat (16) cmd(1);
    chk("gs16", 64'(gs_count), 64'd16);
    cmd(3);
    chk("latgs_code", 64'(cmd_code), 64'd2);
    chk("latgs_gs",   64'(gs_count), 64'd0);

    // Refused WRTCFG, then enabled WRTCFG
    do_reset(1'b0);
    cmd(5);
    chk("refused_cfg",  64'(cfg_data), 64'd0);
    chk("refused_code", 64'(cmd_code), 64'd3);
    cmd(15);
    send_word(48'h1234_5678_9ABC, 5);
    chk("cfg_loaded", 64'(cfg_data), 64'h1234_5678_9ABC);

    // READFC then read the word back on sout, MSB first
    cmd(11);
    chk("readfc_code", 64'(cmd_code), 64'd5);
    for (int i = SRW - 1; i >= 0; i--) begin
      nclk(2);
      v[i] = driver_sout;
      pulse(1'b0);
    end
    chk("readback", 64'(v), 64'h1234_5678_9ABC);

    // Invalid counts and counter saturation (33 would wrap to WRTGS)
    do_reset(1'b0);
    cmd(4);
    cmd(40);
    cmd(33);
    chk("sat_code", 64'(cmd_code), 64'd0);
    chk("sat_gs",   64'(gs_count), 64'd0);
    cmd(2);
    cmd(13);
    chk("tmgrst_code", 64'(cmd_code), 64'd6);

    // gs_count saturation, then LINERESET
    do_reset(1'b0);
    repeat (33) cmd(1);
    chk("gs_sat", 64'(gs_count), 64'd31);
    cmd(7);
    chk("linereset_gs", 64'(gs_count), 64'd0);

    // Reset mid-window discards it; next window decodes
    lat_rise();
    pulse(1'b1);
    pulse(1'b0);
    do_reset(1'b0);
    nclk(6);
    cmd(1);
    chk("after_rst_code", 64'(cmd_code), 64'd1);
    chk("after_rst_gs",   64'(gs_count), 64'd1);

    // lat held high through reset release opens a fresh window
    lat_rise();
    pulse(1'b1);
    do_reset(1'b1);
    pulse(1'b1);
    lat_fall();
    chk("lat_held_code", 64'(cmd_code), 64'd1);
    chk("lat_held_data", 64'(cmd_data), 64'd1);

    nclk(10);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
